// File: rtl/ram_be_dp.sv
// Simple dual-port RAM with per-byte write enables, registered read with valid
// pulse, selectable read-during-write mode and a zero-fill FSM after reset.
// Optional macro RAM_OUT_REG_EN adds a second output register (read latency 2).
module ram_be_dp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 4096,
  parameter int RDW_MODE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en_i,
  input  logic [DATA_W/8-1:0] wr_be_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic                rd_en_i,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                rd_valid_o,
  output logic                busy_o
);

  localparam int NB    = DATA_W / 8;
  localparam int LSB   = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  wr_idx, rd_idx, mem_idx;
  logic [NB-1:0]     mem_be;
  logic [DATA_W-1:0] mem_wdata, rd_word;
  logic              mem_we, wr_fire, rd_fire;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_vld_q;
  logic              unused_addr;

  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [NB-1:0]     be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

  // Byte offset and bits above the word index are deliberately dropped.
  assign wr_idx      = wr_addr_i[LSB +: IDX_W];
  assign rd_idx      = rd_addr_i[LSB +: IDX_W];
  assign unused_addr = ^{wr_addr_i, rd_addr_i};

  assign wr_fire = (state_q == READY) && wr_en_i;
  assign rd_fire = (state_q == READY) && rd_en_i;
  assign busy_o  = (state_q == CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_idx   = wr_idx;
    mem_be    = wr_be_i;
    mem_wdata = wr_data_i;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_idx   = cnt_q;
        mem_be    = '1;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) state_d = READY;
      end
      READY:   mem_we = wr_en_i;
      default: state_d = CLEAR;
    endcase
  end

  // rst_n gate drops any write landing on the edge where reset is asserted.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) begin
      for (int k = 0; k < NB; k++) begin
        if (mem_be[k]) mem[mem_idx][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    rd_word = mem[rd_idx];
    if (RDW_MODE != 0 && wr_fire && (wr_idx == rd_idx))
      rd_word = lane_merge(mem[rd_idx], wr_data_i, wr_be_i);
  end

  // Stage 1: array read, read-during-write resolved here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      rd_vld_q <= rd_fire;
      if (rd_fire) rd_data_q <= rd_word;
    end
  end

`ifdef RAM_OUT_REG_EN
  logic [DATA_W-1:0] rd_data2_q;
  logic              rd_vld2_q;

  // Stage 2: optional output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data2_q <= '0;
      rd_vld2_q  <= 1'b0;
    end else begin
      rd_vld2_q <= rd_vld_q;
      if (rd_vld_q) rd_data2_q <= rd_data_q;
    end
  end

  assign rd_data_o  = rd_data2_q;
  assign rd_valid_o = rd_vld2_q;
`else
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_vld_q;
`endif

endmodule

// File: tb/tb_ram_be_dp.sv
// Directed bench for ram_be_dp: write-first and read-first instances share stimulus.
module tb_ram_be_dp;

`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_be;
  logic [31:0] wr_addr, wr_data;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [31:0] rd_data1, rd_data0;
  logic        rd_valid1, rd_valid0, busy1, busy0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_be_dp #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .RDW_MODE(1)) dut_wf (
    .clk(clk), .rst_n(rst_n),
    .wr_en_i(wr_en), .wr_be_i(wr_be), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data1), .rd_valid_o(rd_valid1), .busy_o(busy1)
  );

  ram_be_dp #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .RDW_MODE(0)) dut_rf (
    .clk(clk), .rst_n(rst_n),
    .wr_en_i(wr_en), .wr_be_i(wr_be), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data0), .rd_valid_o(rd_valid0), .busy_o(busy0)
  );

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Issues one read and returns at the negedge where its result is visible.
  task automatic do_read(input logic [31:0] a);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    for (int i = 1; i < LAT; i++) @(negedge clk);
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (busy1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy1); end
    checks++; if (rd_valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rd_valid1); end
    checks++; if (rd_data1 !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", rd_data1); end
  endtask

  task automatic test_clear;
    int n;
    logic any_vld;
    any_vld = 1'b0;
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 32'h4; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 32'h4;
    n = 0;
    while (busy1 && n < 100) begin
      @(negedge clk);
      n++;
      any_vld = any_vld | rd_valid1;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (n !== 16) begin errors++; $display("FAIL clear_cycles: got %0d expected 16", n); end
    checks++; if (any_vld !== 1'b0) begin errors++; $display("FAIL clear_valid: got %b expected 0", any_vld); end
    do_read(32'h4);
    checks++; if (rd_data1 !== 32'h0) begin errors++; $display("FAIL clear_ignored_wr: got %h expected 00000000", rd_data1); end
    checks++; if (rd_valid1 !== 1'b1) begin errors++; $display("FAIL clear_rd_valid: got %b expected 1", rd_valid1); end
    @(negedge clk);
    checks++; if (rd_valid1 !== 1'b0) begin errors++; $display("FAIL valid_drop: got %b expected 0", rd_valid1); end
  endtask

  task automatic test_byte_enable;
    do_write(32'h8, 32'h11223344, 4'b1111);
    do_write(32'h8, 32'hAABBCCDD, 4'b0101);
    do_read(32'h8);
    checks++; if (rd_data1 !== 32'h11BB33DD) begin errors++; $display("FAIL be_merge: got %h expected 11BB33DD", rd_data1); end
    do_write(32'h8, 32'hFFFFFFFF, 4'b0000);
    do_read(32'h8);
    checks++; if (rd_data1 !== 32'h11BB33DD) begin errors++; $display("FAIL be_zero_noop: got %h expected 11BB33DD", rd_data1); end
  endtask

  task automatic test_wrap;
    do_write(32'h44, 32'hCAFEF00D, 4'hF);
    do_read(32'h04);
    checks++; if (rd_data1 !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap: got %h expected CAFEF00D", rd_data1); end
    do_read(32'h06);
    checks++; if (rd_data1 !== 32'hCAFEF00D) begin errors++; $display("FAIL offset_ignored: got %h expected CAFEF00D", rd_data1); end
  endtask

  task automatic test_rdw;
    do_write(32'h10, 32'hFFFFFFFF, 4'hF);
    wr_en = 1'b1; wr_addr = 32'h10; wr_data = 32'h12345678; wr_be = 4'b0011;
    rd_en = 1'b1; rd_addr = 32'h10;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    for (int i = 1; i < LAT; i++) @(negedge clk);
    checks++; if (rd_data1 !== 32'hFFFF5678) begin errors++; $display("FAIL rdw_write_first: got %h expected FFFF5678", rd_data1); end
    checks++; if (rd_data0 !== 32'hFFFFFFFF) begin errors++; $display("FAIL rdw_read_first: got %h expected FFFFFFFF", rd_data0); end
    do_read(32'h10);
    checks++; if (rd_data1 !== 32'hFFFF5678) begin errors++; $display("FAIL rdw_after_wf: got %h expected FFFF5678", rd_data1); end
    checks++; if (rd_data0 !== 32'hFFFF5678) begin errors++; $display("FAIL rdw_after_rf: got %h expected FFFF5678", rd_data0); end
    // Different indices in the same cycle are independent.
    wr_en = 1'b1; wr_addr = 32'h14; wr_data = 32'h5A5A0F0F; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 32'h8;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    for (int i = 1; i < LAT; i++) @(negedge clk);
    checks++; if (rd_data0 !== 32'h11BB33DD) begin errors++; $display("FAIL diff_idx_rd: got %h expected 11BB33DD", rd_data0); end
    do_read(32'h14);
    checks++; if (rd_data1 !== 32'h5A5A0F0F) begin errors++; $display("FAIL diff_idx_wr: got %h expected 5A5A0F0F", rd_data1); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [3];
    logic [31:0] exps  [3];
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
    exps[0]  = 32'h0BADF00D; exps[1] = 32'hCAFEF00D; exps[2] = 32'h11BB33DD;
    do_write(32'h0, 32'h0BADF00D, 4'hF);
    for (int i = 0; i < 3 + LAT; i++) begin
      if (i < 3) begin rd_en = 1'b1; rd_addr = addrs[i]; end
      else rd_en = 1'b0;
      @(negedge clk);
      if (i + 1 >= LAT && i + 1 - LAT < 3) begin
        checks++;
        if (rd_valid1 !== 1'b1 || rd_data1 !== exps[i+1-LAT]) begin
          errors++;
          $display("FAIL b2b_%0d: got valid=%b data=%h expected valid=1 data=%h", i + 1 - LAT, rd_valid1, rd_data1, exps[i+1-LAT]);
        end
      end
    end
    checks++; if (rd_valid1 !== 1'b0) begin errors++; $display("FAIL b2b_valid_low: got %b expected 0", rd_valid1); end
    checks++; if (rd_data1 !== 32'h11BB33DD) begin errors++; $display("FAIL b2b_hold: got %h expected 11BB33DD", rd_data1); end
  endtask

  task automatic test_reset_mid_read;
    int n;
    rd_en = 1'b1; rd_addr = 32'h8;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (rd_valid1 !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", rd_valid1); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b expected 1", busy1); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear(n);
    checks++; if (n !== 16) begin errors++; $display("FAIL reclear_cycles: got %0d expected 16", n); end
    do_read(32'h8);
    checks++; if (rd_data1 !== 32'h0 || rd_valid1 !== 1'b1) begin
      errors++; $display("FAIL reclear_data: got valid=%b data=%h expected valid=1 data=00000000", rd_valid1, rd_data1);
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_be = 4'h0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    test_reset();
    test_clear();
    test_byte_enable();
    test_wrap();
    test_rdw();
    test_back_to_back();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_be_dp.md
Name: ram_be_dp

Overview:
- Parametrised successor to the single-word data RAM.
- Simple dual-port memory: one write port, one read port, one clock.
- Adds per-byte write enables, a read-enable/valid handshake and a selectable read-during-write mode.
- Adds a hardware zero-fill state machine after reset.
- Sits behind the core's data-bus arbiter as data/stack memory; also instantiated as peripheral scratch RAM.

Parameters:
- DATA_W, 32: data word width in bits; multiple of 8.
- ADDR_W, 32: byte-address width of wr_addr_i/rd_addr_i.
- DEPTH, 4096: number of words; power of 2, at least 2.
- RDW_MODE, 1: read-during-write to the same word. 1 = write-first (new data returned); 0 = read-first (old data returned).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en_i  input  1  write request.
- wr_be_i  input  DATA_W/8  byte-lane write enables; bit k covers bits [8k+7:8k].
- wr_addr_i  input  ADDR_W  write byte address.
- wr_data_i  input  DATA_W  write data.
- rd_en_i  input  1  read request.
- rd_addr_i  input  ADDR_W  read byte address.
- rd_data_o  output  DATA_W  registered read data.
- rd_valid_o  output  1  one-cycle pulse marking rd_data_o as new.
- busy_o  output  1  high while zero-fill runs; requests ignored.

Behaviour:
- Word index = addr[LSB +: log2(DEPTH)], where LSB = log2(DATA_W/8). Byte-offset bits and bits above the index are ignored, so addresses wrap modulo DEPTH words.
- Reset (rst_n low, asynchronous):
  - state=CLEAR, clear counter=0.
  - busy_o=1, rd_valid_o=0, rd_data_o=0.
  - Memory array is not reset directly; it is cleared by the FSM.
- FSM has two states: CLEAR and READY.
- CLEAR:
  - Each cycle writes all-zero to entry[counter], then counter+1.
  - After the write of entry DEPTH-1, the next state is READY and busy_o=0.
  - Takes exactly DEPTH cycles after rst_n deasserts.
- In CLEAR, wr_en_i and rd_en_i are ignored: no array write, rd_valid_o stays 0.
- READY is terminal until the next reset.
- Write (READY, wr_en_i=1): on the clock edge, each lane with wr_be_i[k]=1 is updated; other lanes are unchanged. wr_be_i=0 is a legal no-op.
- Read (READY, rd_en_i=1 at edge N):
  - Index sampled at edge N.
  - rd_data_o updated and rd_valid_o=1 during cycle N+1, i.e. latency 1.
  - rd_valid_o returns to 0 the following cycle unless another read was issued.
- rd_en_i=0: rd_data_o holds its last value and rd_valid_o=0.
- Back-to-back reads: one per cycle, rd_valid_o held high.
- Same-cycle read and write to the same index:
  - RDW_MODE=1: enabled lanes return wr_data_i; disabled lanes return stored data.
  - RDW_MODE=0: the full old word is returned.
  - Array is updated in both modes.
- Same-cycle read and write to different indices: independent, no stall.
- Reset asserted mid-read or mid-clear:
  - Pending read is discarded; rd_valid_o=0 immediately.
  - Clear restarts from index 0.
  - A write on the edge coincident with reset assertion is lost.

Optional Feature:
- Macro RAM_OUT_REG_EN.
- Defined:
  - Adds an output pipeline register after the array read; read latency becomes 2.
  - rd_data_o/rd_valid_o are driven from the second stage, reset to 0.
  - Read-during-write resolution applies at the first stage.
  - Holding rule is unchanged: stage-2 data updates only when stage-1 valid=1.
- Not defined: latency 1 as above, no extra register.

Test Plan (DATA_W=32, DEPTH=16, RDW_MODE=1, macro undefined unless stated):
- Release rst_n, count cycles -> busy_o=1 for exactly 16 cycles then 0. A write of 0xDEADBEEF to 0x4 issued during CLEAR is ignored; later read of 0x4 returns 0x00000000 with rd_valid_o=1 one cycle after rd_en_i.
- Write 0x11223344 to 0x8 with be=4'b1111, then 0xAABBCCDD with be=4'b0101, then read 0x8 -> 0x11BB33DD.
- Write 0xCAFEF00D to 0x44, then read 0x04 -> 0xCAFEF00D (wrap at DEPTH=16). Read 0x06 -> same word (offset ignored).
- Same cycle: write 0x12345678 be=4'b0011 to 0x10 (old 0xFFFFFFFF) and read 0x10 -> 0xFFFF5678. With RDW_MODE=0 -> 0xFFFFFFFF; next read returns 0xFFFF5678 in both modes.
- Reads of 0x0,0x4,0x8 on three consecutive cycles -> rd_valid_o high three cycles, data in order. rd_en_i then low -> rd_valid_o=0, rd_data_o holds the 0x8 data.
- RAM_OUT_REG_EN defined: read issued at edge N -> rd_valid_o and data at N+2. Assert rst_n low mid-pipeline -> rd_valid_o=0 at once, busy_o=1 and clear restarts for 16 cycles.
